// File: rtl/pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_capture                                                  |
// | Description : Measures high/low pulse widths of a PWM input in clk cycles; |
// |               optional stuck-input detector via PWM_CAPTURE_STUCK_DETECT_EN|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module pwm_capture #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   input  logic             clear,
   input  logic             ack,
   output logic [WIDTH-1:0] high_time,
   output logic [WIDTH-1:0] low_time,
   output logic             valid,
   output logic             sat,
   output logic             overrun,
   output logic             stuck
);

   localparam logic [1:0]       c_idle  = 2'd0;
   localparam logic [1:0]       c_armed = 2'd1;
   localparam logic [1:0]       c_high  = 2'd2;
   localparam logic [1:0]       c_low   = 2'd3;
   localparam logic [WIDTH-1:0] c_max   = '1;

   logic [SYNC_STAGES-1:0] r_sync;
   logic [SYNC_STAGES:0]   r_fill;
   logic                   r_s_d, r_rise, r_fall;
   logic                   w_ready;

   // r_fill marks when s_d holds a genuine sample, so a high level present
   // at reset is not mistaken for the low phase needed to arm.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_fill <= '0;
         r_s_d  <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
         r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
         r_s_d  <= r_sync[SYNC_STAGES-1];
         r_rise <= r_sync[SYNC_STAGES-1] & ~r_s_d;
         r_fall <= ~r_sync[SYNC_STAGES-1] & r_s_d;
      end
   end

   assign w_ready = r_fill[SYNC_STAGES];

   logic [1:0]       r_state, w_state_nxt;
   logic [WIDTH-1:0] r_cnt, w_cnt_nxt, r_hi_tmp;
   logic             r_ph_sat, w_ph_sat_nxt, r_hi_sat;
   logic             w_load, w_counting, w_latch_hi, w_publish;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_state <= c_idle;
      else if (clear) r_state <= c_idle;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_idle:  if (w_ready && !r_s_d) w_state_nxt = c_armed;
         c_armed: if (r_rise)            w_state_nxt = c_high;
         c_high:  if (r_fall)            w_state_nxt = c_low;
         c_low:   if (r_rise)            w_state_nxt = c_high;
         default:                        w_state_nxt = c_idle;
      endcase
   end

   always_comb begin
      w_counting   = (r_state == c_high) || (r_state == c_low);
      w_latch_hi   = (r_state == c_high) && r_fall;
      w_publish    = (r_state == c_low)  && r_rise;
      w_load       = ((r_state == c_armed) && r_rise) || w_latch_hi || w_publish;
      w_cnt_nxt    = '0;
      w_ph_sat_nxt = r_ph_sat;
      if (w_load) begin
         w_cnt_nxt    = WIDTH'(1);
         w_ph_sat_nxt = 1'b0;
      end else if (w_counting) begin
         // Saturation flags only a true overflow; a width of exactly c_max is exact.
         w_cnt_nxt = (r_cnt == c_max) ? c_max : r_cnt + 1'b1;
         if (r_cnt == c_max) w_ph_sat_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_ph_sat  <= 1'b0;
         r_hi_tmp  <= '0;
         r_hi_sat  <= 1'b0;
         high_time <= '0;
         low_time  <= '0;
         sat       <= 1'b0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
      end else if (clear) begin
         r_cnt     <= '0;
         r_ph_sat  <= 1'b0;
         r_hi_tmp  <= '0;
         r_hi_sat  <= 1'b0;
         high_time <= '0;
         low_time  <= '0;
         sat       <= 1'b0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_ph_sat <= w_ph_sat_nxt;
         if (w_latch_hi) begin
            r_hi_tmp <= r_cnt;
            r_hi_sat <= r_ph_sat;
         end
         if (w_publish) begin
            high_time <= r_hi_tmp;
            low_time  <= r_cnt;
            sat       <= r_hi_sat | r_ph_sat;
            valid     <= 1'b1;
            if (valid && !ack) overrun <= 1'b1;
         end else if (ack) begin
            valid <= 1'b0;
         end
      end
   end

`ifdef PWM_CAPTURE_STUCK_DETECT_EN
   logic [WIDTH-1:0] r_idle_cnt, w_idle_nxt;
   logic             r_stuck;

   always_comb begin
      w_idle_nxt = '0;
      if (!w_counting && !(r_rise || r_fall))
         w_idle_nxt = (r_idle_cnt == c_max) ? c_max : r_idle_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idle_cnt <= '0;
         r_stuck    <= 1'b0;
      end else if (clear) begin
         r_idle_cnt <= '0;
         r_stuck    <= 1'b0;
      end else begin
         r_idle_cnt <= w_idle_nxt;
         if (r_rise || r_fall)
            r_stuck <= 1'b0;
         else if ((w_cnt_nxt == c_max) || (w_idle_nxt == c_max))
            r_stuck <= 1'b1;
      end
   end

   assign stuck = r_stuck;
`else
   assign stuck = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
# pwm_capture

Measures the high and low pulse widths of a PWM waveform, such as the output of the team's `pwm_generator`, in `clk` cycles. It sits directly downstream of the generator, closing the loop for self-test and duty-cycle readback. It publishes one `{high_time, low_time}` pair per complete period through a valid/ack handshake, with overrun and saturation reporting.

## Interface
- `WIDTH`, 16: width of the pulse-width counters and results; matches the generator's 16-bit `data_in`.
- `SYNC_STAGES`, 2: number of synchronizer flops on `pwm_in`; legal values are 2 and above.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `pwm_in` input 1: PWM waveform to measure; may be asynchronous to `clk`.
- `clear` input 1: synchronous restart; same effect as reset except for timing.
- `ack` input 1: consumer accepts the current result; clears `valid`.
- `high_time` output WIDTH: measured high width of the last complete period.
- `low_time` output WIDTH: measured low width of the last complete period.
- `valid` output 1: a result is pending.
- `sat` output 1: the published result contains a saturated width.
- `overrun` output 1: sticky; a result was overwritten while still unacknowledged.
- `stuck` output 1: `pwm_in` has held one level for 2^WIDTH−1 cycles or more (see Configuration).

## Operation
- **Input conditioning.** `pwm_in` passes through a `SYNC_STAGES`-flop synchronizer to give `s`. `s_d` is `s` delayed by one cycle.
  - Rising edge: `s & ~s_d`.
  - Falling edge: `~s & s_d`.
  - All sync flops reset to 0.
- **States:** IDLE, ARMED, MEAS_HIGH, MEAS_LOW. The reset state is IDLE.
  - IDLE → ARMED when `s==0`. This discards any partial high phase present at reset.
  - ARMED → MEAS_HIGH on a rising edge; `cnt` is set to 1.
  - MEAS_HIGH: `cnt` increments each cycle. On a falling edge, `hi_tmp` latches `cnt`, `cnt` is set to 1, and the state moves to MEAS_LOW.
  - MEAS_LOW: `cnt` increments each cycle. On a rising edge, the block publishes `high_time=hi_tmp` and `low_time=cnt`, sets `cnt` to 1, and moves to MEAS_HIGH.
- **Width rule.** A level held for N cycles of `s` measures as N. A generator programmed with high=H and low=L therefore reads back H and L.
- **Arithmetic.** `cnt` saturates at 2^WIDTH−1 and never wraps. Each phase carries a saturation bit. `sat` is the OR of the two phase saturation bits, captured at publish.
- **Handshake.**
  - Publish sets `valid=1`.
  - `ack` with `valid=1` clears `valid` on the next edge.
  - `ack` while `valid=0` is ignored.
- **Overrun.** If a publish occurs while `valid=1` and `ack=0`, the data is overwritten and `overrun` is set. `overrun` is cleared only by `rst` or `clear`.
- **Simultaneous publish and `ack`.** The new data wins, `valid` stays 1, and no overrun is flagged.
- **`clear`.** Takes effect on the next edge:
  - State returns to IDLE.
  - `cnt`, `hi_tmp`, `high_time`, `low_time`, `valid`, `sat`, `overrun` and `stuck` go to 0.
  - Synchronizer contents are preserved.
  - `clear` has priority over publish and `ack`.
- **Reset mid-measurement.** The partial period is discarded and no result is published for it.

## Timing
- Reset values: `high_time=0`, `low_time=0`, `valid=0`, `sat=0`, `overrun=0`, `stuck=0`, state IDLE.
- Edge-detect latency: a `pwm_in` transition sampled at edge k is seen as an `s` edge at edge k+`SYNC_STAGES`.
- Publish latency: `valid` and the data update on edge k+`SYNC_STAGES`+1 after the sampled rising edge that closes the period.
- Outputs are registered and held stable while `valid=1` until the next publish or `clear`.
- Minimum measurable phase is 1 cycle. Pulses narrower than one `clk` period may be missed.
- First result after reset arrives after one discarded partial phase plus one complete period.

## Configuration
- **`PWM_CAPTURE_STUCK_DETECT_EN` defined:**
  - `stuck` asserts on the edge on which `cnt` reaches 2^WIDTH−1 in any state.
  - In IDLE and ARMED, a free-running saturating idle counter provides this count.
  - `stuck` deasserts on the next detected `s` edge, or on `clear` or `rst`.
- **Undefined:** `stuck` is tied to 0, and the idle counter and its compare logic are not built.

## Test plan
- H=3, L=2 periodic waveform, `ack` asserted for 1 cycle after each `valid` → every result is `high_time=3`, `low_time=2`, `sat=0`, `overrun=0`.
- `pwm_in=1` during reset, then H=5, L=7 → first result is 5/7 with no partial-phase result.
- H=2, L=2 with `ack` never asserted → second publish sets `overrun=1` and the data remains 2/2. Then `clear` → all outputs are 0.
- `ack` coincident with a publish edge → `valid` stays 1, new data is visible, `overrun=0`.
- `WIDTH=4`: H=20, L=3 → `high_time=15`, `low_time=3`, `sat=1`. With the macro defined, `stuck=1` after 15 constant cycles and `stuck=0` after the next edge.
- Assert `rst` in MEAS_LOW, release, then run H=4, L=4 → no result for the interrupted period, and the next result is 4/4.
